// File: rtl/vpg_mode_sequencer.sv
// rtl/vpg_mode_sequencer.sv - vsync-aligned run-time video mode switcher for the VGA timing generator
module vpg_mode_sequencer #(
    parameter int NUM_MODES     = 4,
    parameter int DEFAULT_MODE  = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int VS_TIMEOUT    = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        mode_ack,
    output logic        mode_err,
    output logic        busy,
    output logic [1:0]  cur_mode,
    input  logic        vga_vs_in,
    output logic        gen_reset_n,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34
);

    localparam int          SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TO_LAST     = 24'(VS_TIMEOUT - 1);
    localparam logic [2:0]  NM          = 3'(NUM_MODES);
    localparam logic [1:0]  DEF_M       = 2'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        S_BOOT_HOLD, S_IDLE, S_WAIT_VS, S_HOLD, S_LOAD, S_DONE
    } state_t;

    typedef struct packed {
        logic [11:0] ht, hs, hst, he, vt, vs, vst, ve, q1, q2, q3;
    } params_t;

    function automatic params_t mode_params(input logic [1:0] m);
        params_t     p;
        logic [11:0] h;
        case (m)
            2'd0:    begin p.ht = 12'd799;  p.hs = 12'd95;  p.hst = 12'd141; p.he = 12'd781;
                           p.vt = 12'd524;  p.vs = 12'd1;   p.vst = 12'd34;  p.ve = 12'd514;  end
            2'd1:    begin p.ht = 12'd1055; p.hs = 12'd127; p.hst = 12'd212; p.he = 12'd1012;
                           p.vt = 12'd627;  p.vs = 12'd3;   p.vst = 12'd26;  p.ve = 12'd626;  end
            2'd2:    begin p.ht = 12'd1343; p.hs = 12'd135; p.hst = 12'd293; p.he = 12'd1317;
                           p.vt = 12'd805;  p.vs = 12'd5;   p.vst = 12'd34;  p.ve = 12'd802;  end
            default: begin p.ht = 12'd1687; p.hs = 12'd111; p.hst = 12'd357; p.he = 12'd1637;
                           p.vt = 12'd1065; p.vs = 12'd2;   p.vst = 12'd40;  p.ve = 12'd1064; end
        endcase
        // Quarter/half/three-quarter active-line markers
        h    = p.ve - p.vst;
        p.q1 = p.vst + (h >> 2);
        p.q2 = p.vst + (h >> 1);
        p.q3 = p.vst + (h >> 2) + (h >> 1);
        return p;
    endfunction

    state_t      state_q;
    params_t     params_q;
    logic [1:0]  cur_q, tgt_q;
    logic [SW-1:0] settle_q;
    logic [23:0] to_q;
    logic        vs_prev_q, gen_rst_n_q, busy_q, ack_q, err_q;
    logic        vs_fall;

    assign vs_fall = vs_prev_q & ~vga_vs_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BOOT_HOLD;
            params_q    <= mode_params(DEF_M);
            cur_q       <= DEF_M;
            tgt_q       <= DEF_M;
            settle_q    <= '0;
            to_q        <= '0;
            vs_prev_q   <= 1'b1;
            gen_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vs_prev_q <= vga_vs_in;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                S_BOOT_HOLD: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q    <= '0;
                        state_q     <= S_IDLE;
                        gen_rst_n_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (mode_req) begin
                        tgt_q <= mode_sel;
                        if ({1'b0, mode_sel} >= NM) begin
                            err_q <= 1'b1;
                        end else if (mode_sel == cur_q) begin
                            ack_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_VS;
                            busy_q  <= 1'b1;
                            to_q    <= '0;
                        end
                    end
                end
                S_WAIT_VS: begin
                    // Timeout keeps a stalled or disconnected generator from wedging the switch
                    if (vs_fall || to_q == TO_LAST) begin
                        state_q     <= S_HOLD;
                        gen_rst_n_q <= 1'b0;
                        settle_q    <= '0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_LOAD;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    params_q    <= mode_params(tgt_q);
                    cur_q       <= tgt_q;
                    state_q     <= S_DONE;
                    gen_rst_n_q <= 1'b1;
                    ack_q       <= 1'b1;
                    busy_q      <= 1'b0;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_BOOT_HOLD;
            endcase
        end
    end

    assign mode_ack    = ack_q;
    assign mode_err    = err_q;
    assign busy        = busy_q;
    assign cur_mode    = cur_q;
    assign gen_reset_n = gen_rst_n_q;
    assign h_total     = params_q.ht;
    assign h_sync      = params_q.hs;
    assign h_start     = params_q.hst;
    assign h_end       = params_q.he;
    assign v_total     = params_q.vt;
    assign v_sync      = params_q.vs;
    assign v_start     = params_q.vst;
    assign v_end       = params_q.ve;
    assign v_active_14 = params_q.q1;
    assign v_active_24 = params_q.q2;
    assign v_active_34 = params_q.q3;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// tb/tb_vpg_mode_sequencer.sv - randomized mode-switch bench with transaction-level reference model
module tb_vpg_mode_sequencer;

    localparam int SETTLE = 16;
    localparam int BASE [4][8] = '{
        '{799,  95,  141, 781,  524,  1, 34, 514},
        '{1055, 127, 212, 1012, 627,  3, 26, 626},
        '{1343, 135, 293, 1317, 805,  5, 34, 802},
        '{1687, 111, 357, 1637, 1065, 2, 40, 1064}
    };
    localparam int NMODES [2] = '{4, 3};
    localparam int VSTO   [2] = '{2000000, 50};

    logic        clk;
    logic        reset;
    logic        req   [2];
    logic [1:0]  sel   [2];
    logic        vs    [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];
    logic        grn   [2];
    logic [1:0]  cur   [2];
    logic [11:0] p     [2][11];

    int n_err = 0;
    int n_chk = 0;
    int model_cur [2];

    vpg_mode_sequencer u_a (
        .clk(clk), .reset(reset), .mode_req(req[0]), .mode_sel(sel[0]),
        .mode_ack(ack[0]), .mode_err(err[0]), .busy(busy[0]), .cur_mode(cur[0]),
        .vga_vs_in(vs[0]), .gen_reset_n(grn[0]),
        .h_total(p[0][0]), .h_sync(p[0][1]), .h_start(p[0][2]), .h_end(p[0][3]),
        .v_total(p[0][4]), .v_sync(p[0][5]), .v_start(p[0][6]), .v_end(p[0][7]),
        .v_active_14(p[0][8]), .v_active_24(p[0][9]), .v_active_34(p[0][10])
    );

    vpg_mode_sequencer #(.NUM_MODES(3), .VS_TIMEOUT(50)) u_b (
        .clk(clk), .reset(reset), .mode_req(req[1]), .mode_sel(sel[1]),
        .mode_ack(ack[1]), .mode_err(err[1]), .busy(busy[1]), .cur_mode(cur[1]),
        .vga_vs_in(vs[1]), .gen_reset_n(grn[1]),
        .h_total(p[1][0]), .h_sync(p[1][1]), .h_start(p[1][2]), .h_end(p[1][3]),
        .v_total(p[1][4]), .v_sync(p[1][5]), .v_start(p[1][6]), .v_end(p[1][7]),
        .v_active_14(p[1][8]), .v_active_24(p[1][9]), .v_active_34(p[1][10])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_param(input int m, input int f);
        int vst, h;
        if (f < 8) return BASE[m][f];
        vst = BASE[m][6];
        h   = BASE[m][7] - vst;
        case (f)
            8:       return vst + h / 4;
            9:       return vst + h / 2;
            default: return vst + h / 4 + h / 2;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_params(input int k, input int m, input string tag);
        for (int f = 0; f < 11; f++)
            check_eq($sformatf("%s_u%0d_f%0d", tag, k, f), 32'(p[k][f]), 32'(exp_param(m, f)));
        check_eq($sformatf("%s_u%0d_cur", tag, k), 32'(cur[k]), 32'(m));
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0;
            vs[k]  = 1'b1;
        end
        repeat (cycles) step();
        for (int k = 0; k < 2; k++) begin
            check_params(k, 0, "rst");
            check_eq("rst_grn", 32'(grn[k]), 0);
            check_eq("rst_busy", 32'(busy[k]), 1);
            check_eq("rst_ack", 32'(ack[k]), 0);
            check_eq("rst_err", 32'(err[k]), 0);
            model_cur[k] = 0;
        end
        reset = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("boot_grn_c%0d", i), 32'(grn[k]), 0);
                check_eq($sformatf("boot_ack_c%0d", i), 32'(ack[k]), 0);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            check_eq("boot_end_grn", 32'(grn[k]), 1);
            check_eq("boot_end_busy", 32'(busy[k]), 0);
            check_eq("boot_end_ack", 32'(ack[k]), 0);
        end
    endtask

    // d: negedges after WAIT_VS entry before vsync is pulled low
    task automatic request(input int k, input int m, input int d, input bit intrude, input bit rst_in_hold);
        int k_exp, j, lo;
        req[k] = 1'b1;
        sel[k] = 2'(m);
        step();
        req[k] = 1'b0;
        if (m >= NMODES[k]) begin
            check_eq("err_pulse", 32'(err[k]), 1);
            check_eq("err_noack", 32'(ack[k]), 0);
            check_params(k, model_cur[k], "err_keep");
            step();
            check_eq("err_one_cycle", 32'(err[k]), 0);
            return;
        end
        if (m == model_cur[k]) begin
            check_eq("same_ack", 32'(ack[k]), 1);
            check_eq("same_grn", 32'(grn[k]), 1);
            check_eq("same_busy", 32'(busy[k]), 0);
            step();
            check_eq("same_ack_one_cycle", 32'(ack[k]), 0);
            return;
        end
        check_eq("sw_busy", 32'(busy[k]), 1);
        check_eq("sw_grn_wait", 32'(grn[k]), 1);
        k_exp = (d + 1 < VSTO[k]) ? d + 1 : VSTO[k];
        j = 0;
        while (grn[k] === 1'b1 && j < k_exp + 5) begin
            if (j == d) vs[k] = 1'b0;
            step();
            j++;
        end
        check_eq("wait_vs_len", 32'(j), 32'(k_exp));
        vs[k] = 1'b1;
        lo = 0;
        while (grn[k] === 1'b0 && lo < SETTLE + 10) begin
            check_eq("hold_noack", 32'(ack[k]), 0);
            check_eq("hold_busy", 32'(busy[k]), 1);
            if (rst_in_hold && lo == 5) begin
                apply_reset(2);
                return;
            end
            if (intrude && lo == 3) begin
                req[k] = 1'b1;
                sel[k] = 2'((m + 1) % NMODES[k]);
            end else begin
                req[k] = 1'b0;
            end
            step();
            lo++;
        end
        check_eq("hold_len", 32'(lo), 32'(SETTLE + 1));
        check_eq("done_ack", 32'(ack[k]), 1);
        check_eq("done_busy", 32'(busy[k]), 0);
        check_params(k, m, "done");
        model_cur[k] = m;
        step();
        check_eq("done_ack_one_cycle", 32'(ack[k]), 0);
        check_eq("idle_grn", 32'(grn[k]), 1);
        check_params(k, m, "idle");
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0;
            sel[k] = 2'd0;
            vs[k]  = 1'b1;
        end
        step();
        apply_reset(3);
        request(0, 2, 99, 1'b0, 1'b0);
        request(0, 2, 0, 1'b0, 1'b0);
        request(1, 3, 0, 1'b0, 1'b0);
        request(1, 1, 1000, 1'b0, 1'b0);
        request(0, 3, 10, 1'b1, 1'b0);
        check_eq("intrude_final_cur", 32'(cur[0]), 3);
        request(0, 1, 5, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            request(i % 2, $urandom_range(0, 3), $urandom_range(0, 60),
                    1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
